lcd_pattern_gen: RTL

- Pixel-source stage that feeds the LCD output path.
- Consumes the raw hs/vs/de timing stream from the scan generator and counts pixel x/y internally.
- Produces a 24-bit test pattern with hs/vs/de re-aligned to rgb; the result drives lcd_rgb/lcd_hs/lcd_vs/lcd_de.
- Supports four patterns, selected directly or auto-cycled every N frames; changes apply only at frame boundaries.

---
 rtl/lcd_pattern_gen.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/lcd_pattern_gen.sv
// Test-pattern pixel source: counts x/y from incoming hs/vs/de and emits one of four patterns.
// Latency 2 cycles on rgb/hs/vs/de; no backpressure, one pixel per pixel_clk.
module lcd_pattern_gen #(
  parameter int H_ACT        = 800,
  parameter int V_ACT        = 480,
  parameter int SYNC_ACT_LOW = 1,
  parameter int BAR_W        = 100,
  parameter int CHK_LOG2     = 5,
  parameter int BOX_SIZE     = 64,
  parameter int BOX_STEP     = 2,
  parameter int AUTO_FRAMES  = 120
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        de_in,
  input  logic [1:0]  mode_sel,
  input  logic        auto_en,
  output logic [23:0] rgb,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic        frame_start
);

  localparam int   XW        = $clog2(H_ACT);
  localparam int   YW        = $clog2(V_ACT);
  localparam int   FW        = $clog2(AUTO_FRAMES);
  localparam int   BW        = $clog2(BAR_W);
  localparam int   BX_MAX    = H_ACT - BOX_SIZE;
  localparam int   BY_MAX    = V_ACT - BOX_SIZE;
  localparam logic SYNC_IDLE = (SYNC_ACT_LOW != 0);

  typedef enum logic [1:0] {PAT_BARS, PAT_CHECK, PAT_GRAD, PAT_BOX} pat_t;

  logic          vs_d, de_d, fs;
  logic [XW-1:0] x_cnt, x_s1;
  logic [YW-1:0] y_cnt, y_s1;
  logic [BW-1:0] bar_sub;
  logic [2:0]    bar_idx, bar_s1;
  logic [FW-1:0] fcnt;
  pat_t          mode, mode_s1;
  logic          frame_valid;
  logic [XW-1:0] bx, bx_show, bx_nxt;
  logic [YW-1:0] by, by_show, by_nxt;
  logic          bx_neg, by_neg, bx_flip, by_flip;
  logic          hs_s1, vs_s1, de_s1;
  logic [23:0]   colour;
  logic [XW:0]   bx_end;
  logic [YW:0]   by_end;
  logic          in_box;
  int            bx_sum, by_sum;

  assign fs = (vs_in ^ SYNC_IDLE) & ~(vs_d ^ SYNC_IDLE);

  // Next box position: clamp to the visible range and bounce on the limit.
  always_comb begin
    bx_sum  = bx_neg ? int'(bx) - BOX_STEP : int'(bx) + BOX_STEP;
    by_sum  = by_neg ? int'(by) - BOX_STEP : int'(by) + BOX_STEP;
    bx_nxt  = XW'(bx_sum);
    by_nxt  = YW'(by_sum);
    bx_flip = 1'b0;
    by_flip = 1'b0;
    if (bx_sum < 0) begin
      bx_nxt  = '0;
      bx_flip = 1'b1;
    end else if (bx_sum > BX_MAX) begin
      bx_nxt  = XW'(BX_MAX);
      bx_flip = 1'b1;
    end
    if (by_sum < 0) begin
      by_nxt  = '0;
      by_flip = 1'b1;
    end else if (by_sum > BY_MAX) begin
      by_nxt  = YW'(BY_MAX);
      by_flip = 1'b1;
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      vs_d        <= SYNC_IDLE;
      de_d        <= 1'b0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      bar_sub     <= '0;
      bar_idx     <= '0;
      fcnt        <= '0;
      mode        <= PAT_BARS;
      frame_valid <= 1'b0;
      frame_start <= 1'b0;
      bx          <= '0;
      by          <= '0;
      bx_show     <= '0;
      by_show     <= '0;
      bx_neg      <= 1'b0;
      by_neg      <= 1'b0;
    end else begin
      vs_d        <= vs_in;
      de_d        <= de_in;
      frame_start <= fs;
      if (de_in) begin
        if (x_cnt != XW'(H_ACT - 1)) x_cnt <= x_cnt + 1'b1;
        if (bar_sub == BW'(BAR_W - 1)) begin
          bar_sub <= '0;
          if (bar_idx != 3'd7) bar_idx <= bar_idx + 1'b1;
        end else begin
          bar_sub <= bar_sub + 1'b1;
        end
      end else begin
        x_cnt   <= '0;
        bar_sub <= '0;
        bar_idx <= '0;
      end
      if (fs) y_cnt <= '0;
      else if (de_d && !de_in && y_cnt != YW'(V_ACT - 1)) y_cnt <= y_cnt + 1'b1;
      // The frame shows the position held at its start; the stored one moves on.
      if (fs) begin
        frame_valid <= 1'b1;
        bx_show     <= bx;
        by_show     <= by;
        bx          <= bx_nxt;
        by          <= by_nxt;
        bx_neg      <= bx_neg ^ bx_flip;
        by_neg      <= by_neg ^ by_flip;
        if (!auto_en) begin
          mode <= pat_t'(mode_sel);
          fcnt <= '0;
        end else if (fcnt == FW'(AUTO_FRAMES - 1)) begin
          fcnt <= '0;
          mode <= pat_t'(mode + 2'd1);
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bx_end = {1'b0, bx_show} + (XW+1)'(BOX_SIZE);
    by_end = {1'b0, by_show} + (YW+1)'(BOX_SIZE);
    in_box = (x_s1 >= bx_show) && ({1'b0, x_s1} < bx_end) &&
             (y_s1 >= by_show) && ({1'b0, y_s1} < by_end);
    colour = 24'h000000;
    case (mode_s1)
      PAT_BARS: begin
        case (bar_s1)
          3'd0:    colour = 24'hFFFFFF;
          3'd1:    colour = 24'hFFFF00;
          3'd2:    colour = 24'h00FFFF;
          3'd3:    colour = 24'h00FF00;
          3'd4:    colour = 24'hFF00FF;
          3'd5:    colour = 24'hFF0000;
          3'd6:    colour = 24'h0000FF;
          default: colour = 24'h000000;
        endcase
      end
      PAT_CHECK: colour = (x_s1[CHK_LOG2] ^ y_s1[CHK_LOG2]) ? 24'h000000 : 24'hFFFFFF;
      PAT_GRAD:  colour = {3{x_s1[9:2]}};
      PAT_BOX:   colour = in_box ? 24'hFFFFFF : 24'h0000FF;
      default:   colour = 24'h000000;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      x_s1    <= '0;
      y_s1    <= '0;
      bar_s1  <= '0;
      mode_s1 <= PAT_BARS;
      hs_s1   <= SYNC_IDLE;
      vs_s1   <= SYNC_IDLE;
      de_s1   <= 1'b0;
      hs      <= SYNC_IDLE;
      vs      <= SYNC_IDLE;
      de      <= 1'b0;
      rgb     <= '0;
    end else begin
      x_s1    <= x_cnt;
      y_s1    <= y_cnt;
      bar_s1  <= bar_idx;
      mode_s1 <= mode;
      hs_s1   <= hs_in;
      vs_s1   <= vs_in;
      de_s1   <= de_in;
      hs      <= hs_s1;
      vs      <= vs_s1;
      de      <= de_s1;
      rgb     <= (de_s1 && frame_valid) ? colour : 24'h000000;
    end
  end

endmodule
